// File: rtl/lfsr_decrypter_pkg.sv
// Shared definitions for the LFSR stream cipher: tap mask, key-byte and step
// functions, default preamble character and FSM state encoding.
package lfsr_decrypter_pkg;

  // Feedback taps at bit positions 2, 5, 6, 12 and 30.
  localparam logic [31:0] LFSR_TAPS        = 32'h4000_1064;
  localparam logic [7:0]  PRE_CHAR_DEFAULT = 8'h5F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] key_byte(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ {1'b1, v[30:24]};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_decrypter_lfsr.sv
// Keystream generator: 32-bit LFSR, loaded from a seed, stepped once per
// accepted byte; psrByte is the key for the current (pre-step) value.
module lfsr_decrypter_lfsr
  import lfsr_decrypter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ldLFSR,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [7:0]  psrByte
);

  logic [31:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
    end else if (ldLFSR) begin
      lfsr <= seed;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign psrByte = key_byte(lfsr);

endmodule

// File: rtl/lfsr_decrypter.sv
// Receive-side LFSR stream decryptor: strips and checks a fixed preamble, then
// forwards len plaintext bytes through a one-entry output register.
module lfsr_decrypter
  import lfsr_decrypter_pkg::*;
#(
  parameter int unsigned PRE_LEN  = 8,
  parameter logic [7:0]  PRE_CHAR = PRE_CHAR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [7:0]  len,
  input  logic [7:0]  cipher_in,
  input  logic        cipher_valid,
  output logic        cipher_ready,
  output logic [7:0]  plain_out,
  output logic        plain_valid,
  input  logic        plain_ready,
  output logic        busy,
  output logic        done,
  output logic        pre_err
);

  localparam logic [3:0] PRE_LAST = 4'(PRE_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] pre_cnt;
  logic [7:0] pay_cnt;
  logic [7:0] len_q;
  logic [7:0] key;
  logic [7:0] plain;
  logic       load;
  logic       accept;
  logic       out_hs;

  assign load   = (state_q == ST_IDLE) && start;
  assign accept = cipher_valid && cipher_ready;
  assign out_hs = plain_valid && plain_ready;
  assign plain  = cipher_in ^ key;

  lfsr_decrypter_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .ldLFSR (load),
    .seed   (seed),
    .step   (accept),
    .psrByte(key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pay_cnt counts accepted payload bytes; once it reaches len_q the output
  // register holds the last byte, so its handshake ends the message.
  always_comb begin
    state_d      = state_q;
    cipher_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PRE;
      end
      ST_PRE: begin
        cipher_ready = 1'b1;
        busy         = 1'b1;
        if (accept && (pre_cnt == PRE_LAST)) begin
          state_d = (len_q == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        cipher_ready = (!plain_valid || plain_ready) && (pay_cnt != len_q);
        busy         = 1'b1;
        if (out_hs && (pay_cnt == len_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt     <= '0;
      pay_cnt     <= '0;
      len_q       <= '0;
      plain_out   <= '0;
      plain_valid <= 1'b0;
      pre_err     <= 1'b0;
    end else begin
      if (load) begin
        len_q   <= len;
        pre_cnt <= '0;
        pay_cnt <= '0;
        pre_err <= 1'b0;
      end
      if (state_q == ST_PRE && accept) begin
        pre_cnt <= pre_cnt + 4'd1;
        if (plain != PRE_CHAR) pre_err <= 1'b1;
      end
      if (state_q == ST_DATA) begin
        if (accept) begin
          plain_out   <= plain;
          plain_valid <= 1'b1;
          pay_cnt     <= pay_cnt + 8'd1;
        end else if (out_hs) begin
          plain_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_decrypter.sv
// Scoreboard bench for lfsr_decrypter with a two-byte preamble.
module tb_lfsr_decrypter;

  localparam int PRE_LEN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [7:0]  len = '0;
  logic [7:0]  cipher_in = '0;
  logic        cipher_valid = 1'b0;
  logic        cipher_ready;
  logic [7:0]  plain_out;
  logic        plain_valid;
  logic        plain_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        pre_err;

  lfsr_decrypter #(.PRE_LEN(2), .PRE_CHAR(8'h5F)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .len         (len),
    .cipher_in   (cipher_in),
    .cipher_valid(cipher_valid),
    .cipher_ready(cipher_ready),
    .plain_out   (plain_out),
    .plain_valid (plain_valid),
    .plain_ready (plain_ready),
    .busy        (busy),
    .done        (done),
    .pre_err     (pre_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] m_lfsr = '0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  int          pv_cycles = 0, pv_run = 0, pv_max = 0, done_cycles = 0;

  function automatic logic [7:0] tb_key(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ {1'b1, v[30:24]};
  endfunction

  function automatic logic [31:0] tb_step(input logic [31:0] v);
    logic fb;
    fb = v[2] ^ v[5] ^ v[6] ^ v[12] ^ v[30];
    return {v[30:0], fb};
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (m_active && cipher_valid && cipher_ready) begin
        if (m_cnt >= PRE_LEN) exp_q.push_back(cipher_in ^ tb_key(m_lfsr));
        m_lfsr = tb_step(m_lfsr);
        m_cnt++;
      end
      if (plain_valid) begin
        pv_cycles++;
        pv_run++;
        if (pv_run > pv_max) pv_max = pv_run;
      end else begin
        pv_run = 0;
      end
      if (done) done_cycles++;
      if (plain_valid && plain_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: plain_out=%h but no byte expected", plain_out);
        end else begin
          e = exp_q.pop_front();
          if (plain_out !== e) begin
            errors++;
            $display("FAIL scoreboard_data: plain_out=%h expected %h", plain_out, e);
          end
        end
        got_q.push_back(plain_out);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [7:0] l);
    start = 1'b1;
    seed  = s;
    len   = l;
    m_lfsr = s;
    m_cnt = 0;
    m_active = 1'b1;
    exp_q.delete();
    got_q.delete();
    pv_cycles = 0;
    pv_max = 0;
    done_cycles = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    cipher_in = b;
    cipher_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cipher_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cipher_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cipher_ready=%b required 1 within 100 cycles", cipher_ready);
    end
    tick();
    cipher_valid = 1'b0;
  endtask

  task automatic encrypt_and_send(input logic [31:0] s, input logic [7:0] pt[$]);
    logic [31:0] enc;
    logic [7:0]  p;
    enc = s;
    for (int i = 0; i < PRE_LEN + pt.size(); i++) begin
      p = (i < PRE_LEN) ? 8'h5F : pt[i - PRE_LEN];
      send(p ^ tb_key(enc));
      enc = tb_step(enc);
    end
  endtask

  task automatic wait_done(output logic busy_at_done);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    busy_at_done = busy;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1 within 200 cycles", done);
    end
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cipher_ready, plain_valid, plain_out, busy, done, pre_err} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {cipher_ready, plain_valid, plain_out, busy, done, pre_err});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic b;
    do_start(32'h1, 8'd1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    tick();
    send(8'hDE);
    send(8'hDD);
    send(8'hC5);
    wait_done(b);
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: busy=%b required 0", b);
    end
    tick();
    checks++;
    if (pre_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_pre_err: pre_err=%b required 0", pre_err);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
      errors++;
      $display("FAIL basic_plain: got %0d bytes first=%h required 1 byte 41",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++;
    if (done_cycles != 1) begin
      errors++;
      $display("FAIL basic_done_pulse: done high %0d cycles required 1", done_cycles);
    end
  endtask

  task automatic test_pre_err();
    logic b;
    do_start(32'h1, 8'd1);
    send(8'hDE);
    @(negedge clk);
    checks++;
    if (pre_err !== 1'b0) begin
      errors++;
      $display("FAIL pre_err_byte1: pre_err=%b required 0", pre_err);
    end
    tick();
    send(8'hDC);
    @(negedge clk);
    checks++;
    if (pre_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_err_byte2: pre_err=%b required 1", pre_err);
    end
    tick();
    send(8'hC5);
    wait_done(b);
    checks++;
    if (pre_err !== 1'b1 || got_q.size() != 1 || got_q[0] !== 8'h41) begin
      errors++;
      $display("FAIL pre_err_payload: pre_err=%b bytes=%0d required pre_err=1 one byte 41",
               pre_err, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic b;
    do_start(32'h0, 8'd3);
    @(negedge clk);
    checks++;
    if (pre_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre_err_cleared: pre_err=%b required 0", pre_err);
    end
    tick();
    for (int i = 0; i < 5; i++) send(8'hDF);
    wait_done(b);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 8'h5F || got_q[1] !== 8'h5F || got_q[2] !== 8'h5F) begin
      errors++;
      $display("FAIL b2b_payload: got %0d bytes required 3 bytes of 5F", got_q.size());
    end
    checks++;
    if (pv_max != 3 || pv_cycles != 3) begin
      errors++;
      $display("FAIL b2b_valid_run: run=%0d total=%0d required 3 and 3", pv_max, pv_cycles);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pt[$];
    logic [7:0] hold;
    logic       b;
    int         snap;
    pt = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start(32'hACE1_2345, 8'd4);
    fork
      encrypt_and_send(32'hACE1_2345, pt);
      begin
        int n;
        n = 0;
        while (got_q.size() < 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        tick();
        plain_ready = 1'b0;
        @(negedge clk);
        hold = plain_out;
        snap = m_cnt;
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (cipher_ready !== 1'b0 || plain_valid !== 1'b1 || plain_out !== hold) begin
            errors++;
            $display("FAIL bp_hold: ready=%b valid=%b out=%h required 0 1 %h",
                     cipher_ready, plain_valid, plain_out, hold);
          end
          if (i < 4) @(negedge clk);
        end
        checks++;
        if (m_cnt != snap) begin
          errors++;
          $display("FAIL bp_no_accept: accepts=%0d required %0d", m_cnt, snap);
        end
        tick();
        plain_ready = 1'b1;
      end
    join
    wait_done(b);
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 0 ||
        got_q[0] !== 8'h11 || got_q[1] !== 8'h22 || got_q[2] !== 8'h33 || got_q[3] !== 8'h44) begin
      errors++;
      $display("FAIL bp_payload: got %0d bytes, %0d pending, required 11 22 33 44",
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] pt[$];
    pt = {};
    do_start(32'h1234_5678, 8'd0);
    encrypt_and_send(32'h1234_5678, pt);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: done=%b busy=%b required 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pv_cycles != 0 || pre_err !== 1'b0) begin
      errors++;
      $display("FAIL len0_after: done=%b valid_cycles=%0d pre_err=%b required 0 0 0",
               done, pv_cycles, pre_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] pt[$];
    logic [31:0] enc;
    logic b;
    do_start(32'hDEAD_BEEF, 8'd4);
    enc = 32'hDEAD_BEEF;
    for (int i = 0; i < PRE_LEN + 2; i++) begin
      send(((i < PRE_LEN) ? 8'h5F : 8'h70 + 8'(i)) ^ tb_key(enc));
      enc = tb_step(enc);
    end
    @(negedge clk);
    tick();
    rst = 1'b1;
    m_active = 1'b0;
    #1;
    checks++;
    if ({cipher_ready, plain_valid, plain_out, busy, done, pre_err} !== 13'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b required all zero",
               {cipher_ready, plain_valid, plain_out, busy, done, pre_err});
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    done_cycles = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done_cycles != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: done high %0d cycles required 0", done_cycles);
    end
    pt = '{8'hA5, 8'h3C};
    do_start(32'hDEAD_BEEF, 8'd2);
    fork
      encrypt_and_send(32'hDEAD_BEEF, pt);
      begin
        tick();
        start = 1'b1;
        seed  = 32'h0;
        len   = 8'd9;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    wait_done(b);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hA5 || got_q[1] !== 8'h3C ||
        pre_err !== 1'b0 || done_cycles != 1) begin
      errors++;
      $display("FAIL restart_decode: bytes=%0d pre_err=%b done=%0d required A5 3C, 0, 1",
               got_q.size(), pre_err, done_cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_pre_err();
    test_back_to_back();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
